// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with hold/bubble control and saturating statistics
module id_exe_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             cnt_clr,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_val1,
    input  logic [31:0]      id_val2,
    input  logic [31:0]      id_st_val,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic [4:0]       id_st_src,
    input  logic [4:0]       id_dest,
    input  logic [3:0]       id_exe_cmd,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             id_wb_en,
    input  logic [1:0]       id_br_type,
    output logic             exe_valid,
    output logic [31:0]      exe_pc,
    output logic [31:0]      exe_val1,
    output logic [31:0]      exe_val2,
    output logic [31:0]      exe_st_val,
    output logic [4:0]       exe_src1,
    output logic [4:0]       exe_src2,
    output logic [4:0]       exe_st_src,
    output logic [4:0]       exe_dest,
    output logic [3:0]       exe_exe_cmd,
    output logic             exe_mem_r_en,
    output logic             exe_mem_w_en,
    output logic             exe_wb_en,
    output logic [1:0]       exe_br_type,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   bubble;
    logic   load;
    logic   clear_fields;

    always_comb begin
        bubble       = !freeze && (flush || hazard);
        load         = !freeze && !flush && !hazard;
        clear_fields = bubble || (load && !id_valid);
        state_nxt    = state;
        if (bubble)
            state_nxt = EMPTY;
        else if (load)
            state_nxt = id_valid ? FULL : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    assign exe_valid = (state == FULL);

    // Freeze falls through both branches, so every field simply keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear_fields) begin
            exe_pc       <= '0;
            exe_val1     <= '0;
            exe_val2     <= '0;
            exe_st_val   <= '0;
            exe_src1     <= '0;
            exe_src2     <= '0;
            exe_st_src   <= '0;
            exe_dest     <= '0;
            exe_exe_cmd  <= '0;
            exe_mem_r_en <= 1'b0;
            exe_mem_w_en <= 1'b0;
            exe_wb_en    <= 1'b0;
            exe_br_type  <= '0;
        end else if (load) begin
            exe_pc       <= id_pc;
            exe_val1     <= id_val1;
            exe_val2     <= id_val2;
            exe_st_val   <= id_st_val;
            exe_src1     <= id_src1;
            exe_src2     <= id_src2;
            exe_st_src   <= id_st_src;
            exe_dest     <= id_dest;
            exe_exe_cmd  <= id_exe_cmd;
            exe_mem_r_en <= id_mem_r_en;
            exe_mem_w_en <= id_mem_w_en;
            exe_wb_en    <= id_wb_en;
            exe_br_type  <= id_br_type;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            freeze_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            freeze_cnt <= '0;
        end else begin
            if (bubble && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (freeze && freeze_cnt != CNT_MAX)
                freeze_cnt <= freeze_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - randomized self-checking bench for id_exe_reg against a stage-level model
module tb_id_exe_reg;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] st_val;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  st_src;
        logic [4:0]  dest;
        logic [3:0]  cmd;
        logic        mem_r;
        logic        mem_w;
        logic        wb;
        logic [1:0]  br;
    } stage_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic freeze = 1'b0, flush = 1'b0, hazard = 1'b0, cnt_clr = 1'b0;
    stage_t in_s = '0;
    stage_t obs;
    logic [CNT_W-1:0] bubble_cnt, freeze_cnt;

    stage_t exp_s = '0;
    int     exp_b = 0;
    int     exp_f = 0;
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard), .cnt_clr(cnt_clr),
        .id_valid(in_s.valid), .id_pc(in_s.pc), .id_val1(in_s.val1), .id_val2(in_s.val2),
        .id_st_val(in_s.st_val), .id_src1(in_s.src1), .id_src2(in_s.src2), .id_st_src(in_s.st_src),
        .id_dest(in_s.dest), .id_exe_cmd(in_s.cmd), .id_mem_r_en(in_s.mem_r), .id_mem_w_en(in_s.mem_w),
        .id_wb_en(in_s.wb), .id_br_type(in_s.br),
        .exe_valid(obs.valid), .exe_pc(obs.pc), .exe_val1(obs.val1), .exe_val2(obs.val2),
        .exe_st_val(obs.st_val), .exe_src1(obs.src1), .exe_src2(obs.src2), .exe_st_src(obs.st_src),
        .exe_dest(obs.dest), .exe_exe_cmd(obs.cmd), .exe_mem_r_en(obs.mem_r), .exe_mem_w_en(obs.mem_w),
        .exe_wb_en(obs.wb), .exe_br_type(obs.br),
        .bubble_cnt(bubble_cnt), .freeze_cnt(freeze_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  32'(obs.valid),  32'(exp_s.valid));
        check({tag, ".pc"},     obs.pc,          exp_s.pc);
        check({tag, ".val1"},   obs.val1,        exp_s.val1);
        check({tag, ".val2"},   obs.val2,        exp_s.val2);
        check({tag, ".st_val"}, obs.st_val,      exp_s.st_val);
        check({tag, ".src1"},   32'(obs.src1),   32'(exp_s.src1));
        check({tag, ".src2"},   32'(obs.src2),   32'(exp_s.src2));
        check({tag, ".st_src"}, 32'(obs.st_src), 32'(exp_s.st_src));
        check({tag, ".dest"},   32'(obs.dest),   32'(exp_s.dest));
        check({tag, ".cmd"},    32'(obs.cmd),    32'(exp_s.cmd));
        check({tag, ".mem_r"},  32'(obs.mem_r),  32'(exp_s.mem_r));
        check({tag, ".mem_w"},  32'(obs.mem_w),  32'(exp_s.mem_w));
        check({tag, ".wb"},     32'(obs.wb),     32'(exp_s.wb));
        check({tag, ".br"},     32'(obs.br),     32'(exp_s.br));
        check({tag, ".bcnt"},   32'(bubble_cnt), exp_b);
        check({tag, ".fcnt"},   32'(freeze_cnt), exp_f);
    endtask

    // Model one edge: hold, bubble or load of the whole stage as a unit.
    task automatic step(input string tag);
        if (freeze) begin
            exp_f = (exp_f < CMAX) ? exp_f + 1 : CMAX;
        end else if (flush || hazard) begin
            exp_s = '0;
            exp_b = (exp_b < CMAX) ? exp_b + 1 : CMAX;
        end else begin
            exp_s = in_s.valid ? in_s : '0;
        end
        if (cnt_clr) begin
            exp_b = 0;
            exp_f = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_in();
        in_s.valid  = ($urandom_range(3) != 0);
        in_s.pc     = $urandom;
        in_s.val1   = $urandom;
        in_s.val2   = $urandom;
        in_s.st_val = $urandom;
        in_s.src1   = 5'($urandom);
        in_s.src2   = 5'($urandom);
        in_s.st_src = 5'($urandom);
        in_s.dest   = 5'($urandom);
        in_s.cmd    = 4'($urandom);
        in_s.mem_r  = 1'($urandom);
        in_s.mem_w  = 1'($urandom);
        in_s.wb     = 1'($urandom);
        in_s.br     = 2'($urandom);
    endtask

    task automatic ctl(input logic fz, input logic fl, input logic hz, input logic cl);
        freeze = fz; flush = fl; hazard = hz; cnt_clr = cl;
    endtask

    initial begin
        #13;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic load
        rand_in();
        in_s = '0; in_s.valid = 1'b1; in_s.pc = 32'h40; in_s.dest = 5'd5; in_s.wb = 1'b1;
        ctl(0, 0, 0, 0);
        step("load");
        check("load.pc_abs", obs.pc, 32'h40);

        // Freeze for three edges while ID changes
        in_s.dest = 5'd9;
        ctl(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("freeze");
        check("freeze.dest_abs", 32'(obs.dest), 32'd5);
        check("freeze.cnt_abs", 32'(freeze_cnt), 32'd3);
        ctl(0, 0, 0, 0);
        step("unfreeze");

        // Freeze beats flush, then flush alone bubbles
        ctl(1, 1, 0, 0);
        step("prio_hold");
        ctl(0, 1, 0, 0);
        step("prio_flush");

        // Hazard bubble, then flush+hazard counted once
        rand_in(); in_s.valid = 1'b1; in_s.src1 = 5'd3; in_s.wb = 1'b1; in_s.mem_w = 1'b1;
        ctl(0, 0, 0, 0);
        step("haz_load");
        in_s.src1 = 5'd7;
        ctl(0, 0, 1, 0);
        step("hazard");
        ctl(0, 1, 1, 0);
        step("flush_hazard");

        // Load with id_valid=0 gives a bubble-valued stage
        rand_in(); in_s.valid = 1'b0;
        ctl(0, 0, 0, 0);
        step("invalid_load");

        // Saturation then clear during a bubble
        ctl(0, 0, 0, 1);
        step("clr");
        ctl(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step("sat");
        check("sat.bcnt_abs", 32'(bubble_cnt), 32'd15);
        ctl(0, 1, 0, 1);
        step("clr_bubble");
        check("clr.bcnt_abs", 32'(bubble_cnt), 32'd0);

        // Asynchronous reset while FULL, mid-cycle
        rand_in(); in_s.valid = 1'b1;
        ctl(0, 0, 0, 0);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_s = '0; exp_b = 0; exp_f = 0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rand_in(); in_s.valid = 1'b1;
        step("post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_in();
            ctl($urandom_range(4) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                $urandom_range(19) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter CNT_W, default 16, width of both statistics counters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 freeze  in  1  global hold (memory wait); no field changes.
REQ-005 flush  in  1  taken branch resolved in EXE; load bubble.
REQ-006 hazard  in  1  load-use stall from hazard detection; load bubble (IF/ID held upstream).
REQ-007 cnt_clr  in  1  synchronous clear of both counters.
REQ-008 id_valid in 1 / exe_valid out 1: instruction-present flag.
REQ-009 id_pc, id_val1, id_val2, id_st_val in 32 / exe_* out 32: PC, operand 1, operand 2, store data.
REQ-010 id_src1, id_src2, id_st_src, id_dest in 5 / exe_* out 5: register numbers feeding EXE-stage forwarding comparison.
REQ-011 id_exe_cmd in 4 / exe_exe_cmd out 4: ALU command.
REQ-012 id_mem_r_en, id_mem_w_en, id_wb_en in 1 / exe_* out 1: memory read, memory write, write-back enables.
REQ-013 id_br_type in 2 / exe_br_type out 2: 0 none, 1 BEZ, 2 BNE, 3 JMP.
REQ-014 bubble_cnt  out  CNT_W  cycles in which a bubble was loaded.
REQ-015 freeze_cnt  out  CNT_W  cycles in which freeze was asserted.

Function
REQ-016 Each rising edge SHALL apply exactly one action, priority freeze > flush > hazard > load.
REQ-017 HOLD (freeze=1): all exe_* outputs SHALL retain their values, regardless of flush/hazard.
REQ-018 BUBBLE (freeze=0, flush=1 or hazard=1): every exe_* output, including src/dest fields and exe_valid, SHALL become 0.
REQ-019 A bubble SHALL have exe_wb_en=0 and exe_mem_w_en=0 so that it never causes forwarding or a memory write.
REQ-020 LOAD (freeze=flush=hazard=0): every exe_* output SHALL take its id_* value; latency exactly one cycle.
REQ-021 LOAD with id_valid=0 SHALL load the bubble value of REQ-018, regardless of other id_* values.
REQ-022 The internal state SHALL be a two-state machine, EMPTY (exe_valid=0) and FULL (exe_valid=1).
REQ-023 EMPTY->FULL SHALL occur on LOAD with id_valid=1; FULL->EMPTY SHALL occur on BUBBLE or on LOAD with id_valid=0; HOLD keeps the state.
REQ-024 bubble_cnt SHALL increment by 1 on each BUBBLE edge, including flush+hazard together (one count).
REQ-025 freeze_cnt SHALL increment by 1 on each edge with freeze=1.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 cnt_clr=1 SHALL zero both counters on that edge, overriding any increment; it SHALL not affect pipeline fields.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force all exe_* outputs and both counters to 0 (state EMPTY).
REQ-030 rst_n asserted during FULL or HOLD SHALL discard the held instruction.
REQ-031 The first edge after rst_n rises SHALL be a normal action per REQ-016.

Verification
REQ-032 Load: id_valid=1, id_pc=0x40, id_dest=5, id_wb_en=1, controls low -> next edge exe_pc=0x40, exe_dest=5, exe_wb_en=1, exe_valid=1.
REQ-033 Freeze: FULL with exe_dest=5, freeze=1 for 3 edges, id_dest=9 -> exe_dest stays 5 and freeze_cnt=3; then freeze=0 -> exe_dest=9.
REQ-034 Priority: freeze=1 and flush=1 -> hold, bubble_cnt unchanged; next edge freeze=0 and flush=1 -> all exe_* 0, bubble_cnt+1.
REQ-035 Hazard: FULL with exe_src1=3, hazard=1 and id_src1=7 -> exe_src1=0, exe_wb_en=0, exe_valid=0; flush+hazard together -> bubble_cnt +1 only.
REQ-036 Saturation/clear: with CNT_W=4, 20 BUBBLE edges -> bubble_cnt=15; cnt_clr=1 during a BUBBLE edge -> bubble_cnt=0.
REQ-037 Async reset: drive rst_n low mid-cycle while FULL -> outputs are 0 before the next clk edge; after release, a LOAD edge loads normally.
